axi_lite_rd_arbiter: RTL and testbench

- Two-to-one AXI-Lite read-channel arbiter; the instruction fetch unit (requester 0) and the load/store unit (requester 1) share one read master port to the memory/bus.
- Owns AR and R channels only; the write channels bypass this block.
- Holds at most one outstanding transaction. The grant is locked from arbitration until the R handshake.
- Includes a response watchdog, so a silent slave cannot hang the core.

---
 rtl/axi_lite_rd_arbiter_pkg.sv | 26 ++
 rtl/axi_lite_rd_arbiter_rr_arb2.sv | 37 +++
 rtl/axi_lite_rd_arbiter.sv | 170 +++++++++++++++++
 tb/tb_axi_lite_rd_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_rd_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_lite_rd_arbiter_pkg : shared AXI response types and arbiter state enum
// Rev 1.0
// ----------------------------------------------------------------------------
package axi_lite_rd_arbiter_pkg;

  // Mirror ysyx_23060251_axi_addr_bus / ysyx_23060251_axi_data_bus widths.
  localparam int c_axi_addr_w = 32;
  localparam int c_axi_data_w = 32;

  typedef logic [1:0] axi_mst_resp_t;

  localparam axi_mst_resp_t c_resp_okay   = 2'b00;
  localparam axi_mst_resp_t c_resp_slverr = 2'b10;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ADDR  = 5'b00010,
    ST_DATA  = 5'b00100,
    ST_ERR   = 5'b01000,
    ST_DRAIN = 5'b10000
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_lite_rd_arbiter_rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_lite_rd_arbiter_rr_arb2 : 2-way round-robin / fixed-priority pick
// Rev 1.0
// ----------------------------------------------------------------------------
module axi_lite_rd_arbiter_rr_arb2 #(
  parameter int PRIO_MODE = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic [1:0] owner_i,
  output logic [1:0] pick_o
);

  // 0 prefers requester 0, 1 prefers requester 1
  logic r_ptr;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ptr <= 1'b0;
    end else if (upd_i && (PRIO_MODE == 0)) begin
      // Finished owner 0 hands preference to 1, and vice versa
      r_ptr <= owner_i[0];
    end
  end

  always_comb begin
    pick_o = req_i;
    if (req_i == 2'b11) begin
      pick_o = ((PRIO_MODE != 0) || r_ptr) ? 2'b10 : 2'b01;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_lite_rd_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_lite_rd_arbiter : 2:1 AXI-Lite read arbiter (IFU/LSU) with R watchdog
// Rev 1.0
// ----------------------------------------------------------------------------
module axi_lite_rd_arbiter
  import axi_lite_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W    = c_axi_addr_w,
  parameter int DATA_W    = c_axi_data_w,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_ar_valid_i,
  input  logic [ADDR_W-1:0] m0_ar_addr_i,
  output logic              m0_ar_ready_o,
  output logic              m0_r_valid_o,
  output logic [DATA_W-1:0] m0_r_data_o,
  output axi_mst_resp_t     m0_r_resp_o,
  input  logic              m0_r_ready_i,
  input  logic              m1_ar_valid_i,
  input  logic [ADDR_W-1:0] m1_ar_addr_i,
  output logic              m1_ar_ready_o,
  output logic              m1_r_valid_o,
  output logic [DATA_W-1:0] m1_r_data_o,
  output axi_mst_resp_t     m1_r_resp_o,
  input  logic              m1_r_ready_i,
  output logic              slv_ar_valid_o,
  output logic [ADDR_W-1:0] slv_ar_addr_o,
  input  logic              slv_ar_ready_i,
  input  logic              slv_r_valid_i,
  input  logic [DATA_W-1:0] slv_r_data_i,
  input  axi_mst_resp_t     slv_r_resp_i,
  output logic              slv_r_ready_o,
  output logic [1:0]        gnt_o,
  output logic              timeout_o
);

  localparam int c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_wd_last = c_cnt_w'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  arb_state_t          r_state, w_state_nxt;
  logic [1:0]          r_gnt, w_gnt_nxt;
  logic [c_cnt_w-1:0]  r_wd_cnt, w_wd_cnt_nxt;
  logic [1:0]          w_req, w_pick;
  logic                w_rr_upd;
  logic                w_win_ar_valid, w_win_r_ready;
  logic [ADDR_W-1:0]   w_win_ar_addr;
  logic                w_ar_ready, w_r_valid, w_wd_fire;
  logic [DATA_W-1:0]   w_r_data;
  axi_mst_resp_t       w_r_resp;

  assign w_req          = {m1_ar_valid_i, m0_ar_valid_i};
  assign w_win_ar_valid = r_gnt[1] ? m1_ar_valid_i : m0_ar_valid_i;
  assign w_win_ar_addr  = r_gnt[1] ? m1_ar_addr_i  : m0_ar_addr_i;
  assign w_win_r_ready  = r_gnt[1] ? m1_r_ready_i  : m0_r_ready_i;

  axi_lite_rd_arbiter_rr_arb2 #(
    .PRIO_MODE (PRIO_MODE)
  ) u_rr_arb2 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (w_req),
    .upd_i   (w_rr_upd),
    .owner_i (r_gnt),
    .pick_o  (w_pick)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 2'b00;
      r_wd_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_wd_cnt <= w_wd_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_wd_cnt_nxt   = r_wd_cnt;
    w_rr_upd       = 1'b0;
    w_wd_fire      = 1'b0;
    w_ar_ready     = 1'b0;
    w_r_valid      = 1'b0;
    w_r_data       = '0;
    w_r_resp       = c_resp_okay;
    slv_ar_valid_o = 1'b0;
    slv_ar_addr_o  = '0;
    slv_r_ready_o  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_gnt_nxt   = w_pick;
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        slv_ar_valid_o = w_win_ar_valid;
        slv_ar_addr_o  = w_win_ar_addr;
        w_ar_ready     = slv_ar_ready_i;
        if (!w_win_ar_valid) begin
          // Requester withdrew: release without touching the RR pointer
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 2'b00;
        end else if (slv_ar_ready_i) begin
          w_state_nxt  = ST_DATA;
          w_wd_cnt_nxt = '0;
        end
      end
      ST_DATA: begin
        w_r_valid     = slv_r_valid_i;
        w_r_data      = slv_r_data_i;
        w_r_resp      = slv_r_resp_i;
        slv_r_ready_o = w_win_r_ready;
        if (slv_r_valid_i && w_win_r_ready) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 2'b00;
          w_rr_upd    = 1'b1;
        end else begin
          if ((TIMEOUT != 0) && (r_wd_cnt == c_wd_last)) begin
            w_wd_fire   = 1'b1;
            w_state_nxt = ST_ERR;
          end
          if (r_wd_cnt != '1) begin
            w_wd_cnt_nxt = r_wd_cnt + c_cnt_w'(1);
          end
        end
      end
      ST_ERR: begin
        w_r_valid = 1'b1;
        w_r_resp  = c_resp_slverr;
        if (w_win_r_ready) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Swallow the late beat so it can never reach the next owner
        slv_r_ready_o = 1'b1;
        if (slv_r_valid_i) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 2'b00;
          w_rr_upd    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 2'b00;
      end
    endcase
  end

  assign m0_ar_ready_o = r_gnt[0] & w_ar_ready;
  assign m0_r_valid_o  = r_gnt[0] & w_r_valid;
  assign m0_r_data_o   = r_gnt[0] ? w_r_data : '0;
  assign m0_r_resp_o   = r_gnt[0] ? w_r_resp : c_resp_okay;
  assign m1_ar_ready_o = r_gnt[1] & w_ar_ready;
  assign m1_r_valid_o  = r_gnt[1] & w_r_valid;
  assign m1_r_data_o   = r_gnt[1] ? w_r_data : '0;
  assign m1_r_resp_o   = r_gnt[1] ? w_r_resp : c_resp_okay;
  assign gnt_o         = r_gnt;
  assign timeout_o     = w_wd_fire;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_rd_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_axi_lite_rd_arbiter : directed checks; dut_a round-robin, dut_b fixed prio
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_axi_lite_rd_arbiter;
  import axi_lite_rd_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        rst_n;
  logic        m0_ar_valid, m0_r_ready, m1_ar_valid, m1_r_ready;
  logic [31:0] m0_ar_addr, m1_ar_addr, slv_r_data;
  logic        slv_ar_ready, slv_r_valid;
  logic [1:0]  slv_r_resp;

  logic        a_m0_ar_ready, a_m0_r_valid, a_m1_ar_ready, a_m1_r_valid;
  logic [31:0] a_m0_r_data, a_m1_r_data, a_slv_ar_addr;
  logic [1:0]  a_m0_r_resp, a_m1_r_resp, a_gnt;
  logic        a_slv_ar_valid, a_slv_r_ready, a_timeout;

  logic        b_m0_ar_ready, b_m0_r_valid, b_m1_ar_ready, b_m1_r_valid;
  logic [31:0] b_m0_r_data, b_m1_r_data, b_slv_ar_addr;
  logic [1:0]  b_m0_r_resp, b_m1_r_resp, b_gnt;
  logic        b_slv_ar_valid, b_slv_r_ready, b_timeout;

  axi_lite_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(0), .TIMEOUT(8)) dut_a (
    .clk_i(clk), .rst_i(rst_n),
    .m0_ar_valid_i(m0_ar_valid), .m0_ar_addr_i(m0_ar_addr), .m0_ar_ready_o(a_m0_ar_ready),
    .m0_r_valid_o(a_m0_r_valid), .m0_r_data_o(a_m0_r_data), .m0_r_resp_o(a_m0_r_resp),
    .m0_r_ready_i(m0_r_ready),
    .m1_ar_valid_i(m1_ar_valid), .m1_ar_addr_i(m1_ar_addr), .m1_ar_ready_o(a_m1_ar_ready),
    .m1_r_valid_o(a_m1_r_valid), .m1_r_data_o(a_m1_r_data), .m1_r_resp_o(a_m1_r_resp),
    .m1_r_ready_i(m1_r_ready),
    .slv_ar_valid_o(a_slv_ar_valid), .slv_ar_addr_o(a_slv_ar_addr), .slv_ar_ready_i(slv_ar_ready),
    .slv_r_valid_i(slv_r_valid), .slv_r_data_i(slv_r_data), .slv_r_resp_i(slv_r_resp),
    .slv_r_ready_o(a_slv_r_ready), .gnt_o(a_gnt), .timeout_o(a_timeout)
  );

  axi_lite_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(1), .TIMEOUT(8)) dut_b (
    .clk_i(clk), .rst_i(rst_n),
    .m0_ar_valid_i(m0_ar_valid), .m0_ar_addr_i(m0_ar_addr), .m0_ar_ready_o(b_m0_ar_ready),
    .m0_r_valid_o(b_m0_r_valid), .m0_r_data_o(b_m0_r_data), .m0_r_resp_o(b_m0_r_resp),
    .m0_r_ready_i(m0_r_ready),
    .m1_ar_valid_i(m1_ar_valid), .m1_ar_addr_i(m1_ar_addr), .m1_ar_ready_o(b_m1_ar_ready),
    .m1_r_valid_o(b_m1_r_valid), .m1_r_data_o(b_m1_r_data), .m1_r_resp_o(b_m1_r_resp),
    .m1_r_ready_i(m1_r_ready),
    .slv_ar_valid_o(b_slv_ar_valid), .slv_ar_addr_o(b_slv_ar_addr), .slv_ar_ready_i(slv_ar_ready),
    .slv_r_valid_i(slv_r_valid), .slv_r_data_i(slv_r_data), .slv_r_resp_i(slv_r_resp),
    .slv_r_ready_o(b_slv_r_ready), .gnt_o(b_gnt), .timeout_o(b_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_ar_valid = 1'b0; m0_ar_addr = '0; m0_r_ready = 1'b0;
    m1_ar_valid = 1'b0; m1_ar_addr = '0; m1_r_ready = 1'b0;
    slv_ar_ready = 1'b0; slv_r_valid = 1'b0; slv_r_data = '0; slv_r_resp = c_resp_okay;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick(); tick(); #3;
    tests++; if (a_gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b expected 00", a_gnt); end
    tests++; if (a_slv_ar_valid !== 1'b0) begin fails++; $display("FAIL reset_ar_valid: got %b expected 0", a_slv_ar_valid); end
    tests++; if (a_slv_r_ready !== 1'b0) begin fails++; $display("FAIL reset_r_ready: got %b expected 0", a_slv_r_ready); end
    tests++; if (a_m0_r_resp !== c_resp_okay) begin fails++; $display("FAIL reset_resp: got %b expected 00", a_m0_r_resp); end
    tests++; if (a_m1_r_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", a_m1_r_data); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    tick();
    m0_ar_valid = 1'b1; m0_ar_addr = 32'h8000_0004; slv_ar_ready = 1'b1;
    #3;
    tests++; if (a_m0_ar_ready !== 1'b0 || a_slv_ar_valid !== 1'b0) begin fails++;
      $display("FAIL fetch_idle_quiet: got ar_ready=%b ar_valid=%b expected 0 0", a_m0_ar_ready, a_slv_ar_valid); end
    tick(); #3;
    tests++; if (a_gnt !== 2'b01) begin fails++; $display("FAIL fetch_gnt: got %b expected 01", a_gnt); end
    tests++; if (a_slv_ar_valid !== 1'b1 || a_slv_ar_addr !== 32'h8000_0004) begin fails++;
      $display("FAIL fetch_ar: got valid=%b addr=%h expected 1 80000004", a_slv_ar_valid, a_slv_ar_addr); end
    tests++; if (a_m0_ar_ready !== 1'b1 || a_m1_ar_ready !== 1'b0) begin fails++;
      $display("FAIL fetch_ar_ready: got m0=%b m1=%b expected 1 0", a_m0_ar_ready, a_m1_ar_ready); end
    tick();
    m0_ar_valid = 1'b0; slv_ar_ready = 1'b0;
    slv_r_valid = 1'b1; slv_r_data = 32'h0000_0013; slv_r_resp = c_resp_okay; m0_r_ready = 1'b1;
    #3;
    tests++; if (a_m0_r_valid !== 1'b1 || a_m0_r_data !== 32'h13 || a_m0_r_resp !== c_resp_okay) begin fails++;
      $display("FAIL fetch_r: got valid=%b data=%h resp=%b expected 1 00000013 00", a_m0_r_valid, a_m0_r_data, a_m0_r_resp); end
    tests++; if (a_m1_r_valid !== 1'b0 || a_m1_r_data !== 32'h0) begin fails++;
      $display("FAIL fetch_m1_quiet: got valid=%b data=%h expected 0 0", a_m1_r_valid, a_m1_r_data); end
    tests++; if (a_slv_r_ready !== 1'b1) begin fails++; $display("FAIL fetch_slv_r_ready: got %b expected 1", a_slv_r_ready); end
    tick();
    clear_inputs();
    #3;
    tests++; if (a_gnt !== 2'b00) begin fails++; $display("FAIL fetch_release: got %b expected 00", a_gnt); end
  endtask

  task automatic test_reset_mid_data();
    tick();
    m1_ar_valid = 1'b1; m1_ar_addr = 32'h4000_0000; slv_ar_ready = 1'b1;
    tick(); #3;
    tests++; if (a_gnt !== 2'b10) begin fails++; $display("FAIL rstmid_gnt: got %b expected 10", a_gnt); end
    tick();
    m1_ar_valid = 1'b0; slv_ar_ready = 1'b0;
    slv_r_valid = 1'b1; slv_r_data = 32'h7777_7777; m1_r_ready = 1'b1;
    #2;
    tests++; if (a_m1_r_valid !== 1'b1 || a_slv_r_ready !== 1'b1) begin fails++;
      $display("FAIL rstmid_pre: got r_valid=%b r_ready=%b expected 1 1", a_m1_r_valid, a_slv_r_ready); end
    rst_n = 1'b0;
    #1;
    tests++; if (a_gnt !== 2'b00) begin fails++; $display("FAIL rstmid_gnt0: got %b expected 00", a_gnt); end
    tests++; if (a_m1_r_valid !== 1'b0 || a_slv_r_ready !== 1'b0 || a_slv_ar_valid !== 1'b0 || a_m1_ar_ready !== 1'b0) begin fails++;
      $display("FAIL rstmid_quiet: got r_valid=%b r_ready=%b ar_valid=%b ar_ready=%b expected 0 0 0 0",
               a_m1_r_valid, a_slv_r_ready, a_slv_ar_valid, a_m1_ar_ready); end
    tests++; if (a_m1_r_data !== 32'h0) begin fails++; $display("FAIL rstmid_data: got %h expected 0", a_m1_r_data); end
    tick();
    clear_inputs();
    rst_n = 1'b1;
    m0_ar_valid = 1'b1; m0_ar_addr = 32'h8000_0000;
    m1_ar_valid = 1'b1; m1_ar_addr = 32'h4000_0000; slv_ar_ready = 1'b1;
    tick(); #3;
    tests++; if (a_gnt !== 2'b01 || a_slv_ar_addr !== 32'h8000_0000) begin fails++;
      $display("FAIL rstmid_first: got gnt=%b addr=%h expected 01 80000000", a_gnt, a_slv_ar_addr); end
    tick();
    m0_ar_valid = 1'b0; m1_ar_valid = 1'b0; slv_ar_ready = 1'b0;
    slv_r_valid = 1'b1; m0_r_ready = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_gnt;
    logic [31:0] exp_addr, exp_data;
    do_reset();
    m0_ar_valid = 1'b1; m0_ar_addr = 32'h0000_1000; m0_r_ready = 1'b1;
    m1_ar_valid = 1'b1; m1_ar_addr = 32'h0000_2000; m1_r_ready = 1'b1;
    slv_ar_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_gnt  = (k % 2 == 1) ? 2'b10 : 2'b01;
      exp_addr = (k % 2 == 1) ? 32'h0000_2000 : 32'h0000_1000;
      exp_data = (k % 2 == 1) ? 32'h5555_0000 : 32'hAAAA_0000;
      #3;
      tests++; if (a_gnt !== 2'b00) begin fails++; $display("FAIL rr_idle[%0d]: got %b expected 00", k, a_gnt); end
      tick(); #3;
      tests++; if (a_gnt !== exp_gnt || a_slv_ar_addr !== exp_addr) begin fails++;
        $display("FAIL rr_grant[%0d]: got gnt=%b addr=%h expected %b %h", k, a_gnt, a_slv_ar_addr, exp_gnt, exp_addr); end
      tick();
      slv_r_valid = 1'b1; slv_r_data = exp_data;
      #3;
      if (exp_gnt[1]) begin
        tests++; if (a_m1_r_valid !== 1'b1 || a_m1_r_data !== exp_data || a_m0_r_valid !== 1'b0) begin fails++;
          $display("FAIL rr_route[%0d]: got m1 valid=%b data=%h m0 valid=%b expected 1 %h 0", k, a_m1_r_valid, a_m1_r_data, a_m0_r_valid, exp_data); end
      end else begin
        tests++; if (a_m0_r_valid !== 1'b1 || a_m0_r_data !== exp_data || a_m1_r_valid !== 1'b0) begin fails++;
          $display("FAIL rr_route[%0d]: got m0 valid=%b data=%h m1 valid=%b expected 1 %h 0", k, a_m0_r_valid, a_m0_r_data, a_m1_r_valid, exp_data); end
      end
      tick();
      slv_r_valid = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_fixed_prio();
    logic [1:0]  exp_gnt;
    logic [31:0] exp_addr;
    do_reset();
    m0_ar_valid = 1'b1; m0_ar_addr = 32'h0000_1000; m0_r_ready = 1'b1;
    m1_ar_valid = 1'b1; m1_ar_addr = 32'h0000_2000; m1_r_ready = 1'b1;
    slv_ar_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) m1_ar_valid = 1'b0;
      exp_gnt  = (k < 3) ? 2'b10 : 2'b01;
      exp_addr = (k < 3) ? 32'h0000_2000 : 32'h0000_1000;
      tick(); #3;
      tests++; if (b_gnt !== exp_gnt || b_slv_ar_addr !== exp_addr) begin fails++;
        $display("FAIL prio_grant[%0d]: got gnt=%b addr=%h expected %b %h", k, b_gnt, b_slv_ar_addr, exp_gnt, exp_addr); end
      tick();
      slv_r_valid = 1'b1; slv_r_data = 32'h0000_0100 + k;
      #3;
      tests++; if ((exp_gnt[1] ? b_m1_r_valid : b_m0_r_valid) !== 1'b1 || (exp_gnt[1] ? b_m0_r_valid : b_m1_r_valid) !== 1'b0) begin fails++;
        $display("FAIL prio_route[%0d]: got m0 valid=%b m1 valid=%b for gnt %b", k, b_m0_r_valid, b_m1_r_valid, exp_gnt); end
      tick();
      slv_r_valid = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_watchdog();
    logic exp_to;
    do_reset();
    m0_ar_valid = 1'b1; m0_ar_addr = 32'h0000_3000; slv_ar_ready = 1'b1;
    tick();
    tick();
    m0_ar_valid = 1'b0; slv_ar_ready = 1'b0; m0_r_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) tick();
      exp_to = (i == 8);
      #3;
      tests++; if (a_timeout !== exp_to || a_m0_r_valid !== 1'b0) begin fails++;
        $display("FAIL wd_data[%0d]: got timeout=%b r_valid=%b expected %b 0", i, a_timeout, a_m0_r_valid, exp_to); end
    end
    tick(); #3;
    tests++; if (a_timeout !== 1'b0 || a_m0_r_valid !== 1'b1 || a_m0_r_resp !== c_resp_slverr || a_m0_r_data !== 32'h0) begin fails++;
      $display("FAIL wd_err: got timeout=%b valid=%b resp=%b data=%h expected 0 1 10 0", a_timeout, a_m0_r_valid, a_m0_r_resp, a_m0_r_data); end
    tests++; if (a_slv_r_ready !== 1'b0 || a_m1_r_valid !== 1'b0) begin fails++;
      $display("FAIL wd_err_quiet: got slv_r_ready=%b m1_valid=%b expected 0 0", a_slv_r_ready, a_m1_r_valid); end
    m0_r_ready = 1'b1;
    tick();
    m0_r_ready = 1'b0;
    slv_r_valid = 1'b1; slv_r_data = 32'hDEAD_BEEF;
    #3;
    tests++; if (a_slv_r_ready !== 1'b1) begin fails++; $display("FAIL wd_drain_ready: got %b expected 1", a_slv_r_ready); end
    tests++; if (a_m0_r_valid !== 1'b0 || a_m1_r_valid !== 1'b0 || a_m0_r_data !== 32'h0 || a_m1_r_data !== 32'h0) begin fails++;
      $display("FAIL wd_drain_leak: got m0 %b/%h m1 %b/%h expected 0/0 0/0", a_m0_r_valid, a_m0_r_data, a_m1_r_valid, a_m1_r_data); end
    tick();
    slv_r_valid = 1'b0;
    #3;
    tests++; if (a_gnt !== 2'b00 || a_m0_r_valid !== 1'b0) begin fails++;
      $display("FAIL wd_back_idle: got gnt=%b r_valid=%b expected 00 0", a_gnt, a_m0_r_valid); end
    clear_inputs();
  endtask

  task automatic test_last_cycle_handshake();
    do_reset();
    m0_ar_valid = 1'b1; m0_ar_addr = 32'h0000_4000; slv_ar_ready = 1'b1;
    tick();
    tick();
    m0_ar_valid = 1'b0; slv_ar_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) tick();
      if (i == 8) begin
        slv_r_valid = 1'b1; slv_r_data = 32'h1234_5678; slv_r_resp = c_resp_okay; m0_r_ready = 1'b1;
      end
      #3;
      tests++; if (a_timeout !== 1'b0) begin fails++; $display("FAIL last_no_timeout[%0d]: got %b expected 0", i, a_timeout); end
    end
    tests++; if (a_m0_r_valid !== 1'b1 || a_m0_r_data !== 32'h1234_5678 || a_m0_r_resp !== c_resp_okay) begin fails++;
      $display("FAIL last_okay: got valid=%b data=%h resp=%b expected 1 12345678 00", a_m0_r_valid, a_m0_r_data, a_m0_r_resp); end
    tick();
    slv_r_valid = 1'b0; m0_r_ready = 1'b0;
    #3;
    tests++; if (a_gnt !== 2'b00 || a_m0_r_valid !== 1'b0 || a_timeout !== 1'b0) begin fails++;
      $display("FAIL last_idle: got gnt=%b valid=%b timeout=%b expected 00 0 0", a_gnt, a_m0_r_valid, a_timeout); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_reset_mid_data();
    test_round_robin();
    test_fixed_prio();
    test_watchdog();
    test_last_cycle_handshake();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
